tree_query_scheduler: RTL and testbench
=======================================

Name: tree_query_scheduler

Overview:
Sequences the internal_node_tree through two phases. In the load phase it enables the tree's node FSM and counts internal-node writes. In the query phase it takes a single in-order stream of tagged patch queries and spreads it round-robin across the tree's two lookup lanes (patch / patch_two). It collects leaf indices from both lanes and returns them in original issue order, with a credit limit sized so the non-stallable tree can never overflow the result buffers.

Parameters:
PATCH_WIDTH, 55, query patch width (5 x 11-bit signed fields)
ADDRESS_WIDTH, 8, leaf index width
TAG_WIDTH, 8, requester tag carried alongside each query
NUM_INTERNAL_NODES, 63, node writes that complete the load phase
MAX_INFLIGHT, 8, maximum queries issued but not yet delivered (power of 2)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
start_load  in  1  pulse; begin load phase
node_wr_en  in  1  one node written into tree (aggregator enq)
tree_fsm_enable  out  1  to tree fsm_enable
load_done  out  1  high while in query phase
q_valid  in  1  query present
q_ready  out  1  query accepted when q_valid & q_ready
q_patch  in  PATCH_WIDTH  query patch
q_tag  in  TAG_WIDTH  query tag
tree_patch_en  out  1  lane A issue pulse
tree_patch_in  out  PATCH_WIDTH  lane A patch
tree_patch_two_en  out  1  lane B issue pulse
tree_patch_two_in  out  PATCH_WIDTH  lane B patch
tree_leaf_en  in  1  lane A result valid
tree_leaf_index  in  ADDRESS_WIDTH  lane A result
tree_leaf_two_en  in  1  lane B result valid
tree_leaf_index_two  in  ADDRESS_WIDTH  lane B result
r_valid  out  1  result available
r_ready  in  1  result consumed when r_valid & r_ready
r_tag  out  TAG_WIDTH  tag of result
r_leaf  out  ADDRESS_WIDTH  leaf index
outstanding  out  $clog2(MAX_INFLIGHT)+1  queries in flight
err_orphan  out  1  sticky; leaf result arrived with no pending query on that lane

Behaviour:
- Reset (rst=1 at posedge): FSM=IDLE; node counter, lane pointer (=A), all FIFOs and outstanding cleared. err_orphan=0. All outputs 0, including patch buses.
- FSM IDLE:
  - start_load -> LOAD.
  - q_ready=0; tree_fsm_enable=0.
- FSM LOAD:
  - tree_fsm_enable=1; each node_wr_en increments the counter.
  - On the cycle node_wr_en arrives with count==NUM_INTERNAL_NODES-1: -> QUERY next cycle. tree_fsm_enable drops that same next cycle, so further writes cannot overwrite nodes.
  - node_wr_en outside LOAD is ignored.
- FSM QUERY:
  - load_done=1.
  - q_ready = (outstanding < MAX_INFLIGHT).
  - start_load -> LOAD (counter cleared) only when outstanding==0; otherwise ignored.
- Issue:
  - Accept at cycle T -> lane en pulse (1 cycle) with registered patch at T+1.
  - Lane chosen by pointer; pointer toggles per accept.
  - At most one issue per cycle, so the A and B enables are never high together.
  - Patch buses hold their last value when en=0.
  - On accept: push tag into lane tag FIFO; push lane bit into order FIFO.
- Completion:
  - tree_leaf_en pops the lane A tag FIFO and pushes {tag, index} into the lane A result FIFO. Same for lane B.
  - Both lanes may complete in the same cycle.
  - Completion with the lane tag FIFO empty: result dropped, err_orphan set (sticky until rst).
- Delivery:
  - r_valid = order FIFO non-empty AND the result FIFO of the head lane is non-empty.
  - r_tag/r_leaf are driven from that FIFO head (combinational from registered FIFO state).
  - On r_valid & r_ready: pop the order FIFO and the head-lane result FIFO.
  - Minimum latency: leaf_en at cycle L -> r_valid at L+1.
- Credit:
  - outstanding +1 on accept, -1 on delivery; unchanged on simultaneous accept and delivery.
  - Never exceeds MAX_INFLIGHT, so no FIFO can overflow. Each FIFO has depth MAX_INFLIGHT.
- r_ready low indefinitely: results accumulate. q_ready falls once outstanding==MAX_INFLIGHT. No result is lost.
- rst mid-query: in-flight queries are discarded. A later late leaf_en from the tree sets err_orphan; the bench must reset the tree alongside.

Decomposition:
- Package tree_sched_pkg:
  - state enum (IDLE, LOAD, QUERY)
  - lane enum (LANE_A=0, LANE_B=1)
  - result struct {tag, leaf}
  - default widths
- Sub-module sched_fifo: synchronous FIFO, parameterised width/depth, with full/empty flags and show-ahead data. Instantiated 5 times: 2 tag FIFOs, 2 result FIFOs, 1 order FIFO.

Test Plan:
1. rst, start_load, 63 node_wr_en pulses with random gaps -> tree_fsm_enable high throughout; falls and load_done rises the cycle after the 63rd; a 64th pulse leaves the counter and state unchanged.
2. After load, queries tag 1 patch [251,-26,-1,-88,79] and tag 2 patch [279,-18,-55,-22,18] back-to-back -> tree_patch_en then tree_patch_two_en on consecutive cycles; results delivered in order: (tag1, leaf 59), then (tag2, leaf 60).
3. Lane B result arrives before lane A (tree model with lane A delay 6, lane B delay 2) for tags 3,4 -> r_valid stays low until lane A completes; output order is tag3, then tag4.
4. r_ready=0, 10 queries offered -> exactly 8 accepted; q_ready=0 with outstanding=8. Raising r_ready drains all 8 in tag order, and the remaining 2 are then accepted.
5. Inject tree_leaf_two_en with no pending lane B query -> err_orphan=1 and stays 1; no r_valid is produced.
6. Assert rst with 4 queries in flight -> next cycle all outputs 0, outstanding=0, FSM IDLE; start_load is needed before q_ready rises again.

Source files
------------

// File: rtl/tree_sched_pkg.sv
// Shared types and default sizes for the tree query scheduler.
package tree_sched_pkg;

  localparam int DEF_PATCH_WIDTH        = 55;
  localparam int DEF_ADDRESS_WIDTH      = 8;
  localparam int DEF_TAG_WIDTH          = 8;
  localparam int DEF_NUM_INTERNAL_NODES = 63;
  localparam int DEF_MAX_INFLIGHT       = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_QUERY = 2'd2;

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  typedef struct packed {
    logic [DEF_TAG_WIDTH-1:0]     tag;
    logic [DEF_ADDRESS_WIDTH-1:0] leaf;
  } result_t;

endpackage

// File: rtl/sched_fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two, at least 2.
module sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tree_query_scheduler.sv
// Load/query sequencer for internal_node_tree: spreads queries over two
// lookup lanes and returns leaf results in original issue order.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | after reset; tree disabled, no queries accepted
//   ST_LOAD  | tree node FSM enabled, counting internal-node writes
//   ST_QUERY | tree loaded; queries issued round-robin to lanes A/B
module tree_query_scheduler
  import tree_sched_pkg::*;
#(
  parameter int PATCH_WIDTH        = DEF_PATCH_WIDTH,
  parameter int ADDRESS_WIDTH      = DEF_ADDRESS_WIDTH,
  parameter int TAG_WIDTH          = DEF_TAG_WIDTH,
  parameter int NUM_INTERNAL_NODES = DEF_NUM_INTERNAL_NODES,
  parameter int MAX_INFLIGHT       = DEF_MAX_INFLIGHT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_load,
  input  logic                              node_wr_en,
  output logic                              tree_fsm_enable,
  output logic                              load_done,
  input  logic                              q_valid,
  output logic                              q_ready,
  input  logic [PATCH_WIDTH-1:0]            q_patch,
  input  logic [TAG_WIDTH-1:0]              q_tag,
  output logic                              tree_patch_en,
  output logic [PATCH_WIDTH-1:0]            tree_patch_in,
  output logic                              tree_patch_two_en,
  output logic [PATCH_WIDTH-1:0]            tree_patch_two_in,
  input  logic                              tree_leaf_en,
  input  logic [ADDRESS_WIDTH-1:0]          tree_leaf_index,
  input  logic                              tree_leaf_two_en,
  input  logic [ADDRESS_WIDTH-1:0]          tree_leaf_index_two,
  output logic                              r_valid,
  input  logic                              r_ready,
  output logic [TAG_WIDTH-1:0]              r_tag,
  output logic [ADDRESS_WIDTH-1:0]          r_leaf,
  output logic [$clog2(MAX_INFLIGHT):0]     outstanding,
  output logic                              err_orphan
);

  localparam int CNT_W = $clog2(NUM_INTERNAL_NODES + 1);
  localparam int OUT_W = $clog2(MAX_INFLIGHT) + 1;
  localparam int RES_W = TAG_WIDTH + ADDRESS_WIDTH;

  logic [1:0]             state_q, state_d;
  logic [CNT_W-1:0]       node_cnt_q, node_cnt_d;
  lane_e                  lane_ptr_q, lane_ptr_d;
  logic [OUT_W-1:0]       outstanding_q, outstanding_d;
  logic                   err_orphan_q, err_orphan_d;
  logic                   en_a_q, en_a_d, en_b_q, en_b_d;
  logic [PATCH_WIDTH-1:0] patch_a_q, patch_a_d, patch_b_q, patch_b_d;

  logic                   accept, deliver, head_is_b, any_full;
  logic                   push_a, push_b, comp_a, comp_b;
  logic [TAG_WIDTH-1:0]   tag_a_head, tag_b_head;
  logic                   tag_a_full, tag_a_empty, tag_b_full, tag_b_empty;
  logic [RES_W-1:0]       res_a_head, res_b_head, head_res;
  logic                   res_a_full, res_a_empty, res_b_full, res_b_empty;
  logic [0:0]             ord_head;
  logic                   ord_full, ord_empty;

  assign any_full = tag_a_full | tag_b_full | res_a_full | res_b_full | ord_full;
  assign q_ready  = (state_q == ST_QUERY) &&
                    (outstanding_q < OUT_W'(MAX_INFLIGHT)) && !any_full;
  assign accept   = q_valid & q_ready;
  assign push_a   = accept & (lane_ptr_q == LANE_A);
  assign push_b   = accept & (lane_ptr_q == LANE_B);
  assign comp_a   = tree_leaf_en & ~tag_a_empty;
  assign comp_b   = tree_leaf_two_en & ~tag_b_empty;

  assign head_is_b = ord_head[0];
  assign r_valid   = ~ord_empty & (head_is_b ? ~res_b_empty : ~res_a_empty);
  assign deliver   = r_valid & r_ready;
  assign head_res  = head_is_b ? res_b_head : res_a_head;
  assign r_tag     = r_valid ? head_res[RES_W-1 -: TAG_WIDTH] : '0;
  assign r_leaf    = r_valid ? head_res[ADDRESS_WIDTH-1:0] : '0;

  assign tree_fsm_enable   = (state_q == ST_LOAD);
  assign load_done         = (state_q == ST_QUERY);
  assign tree_patch_en     = en_a_q;
  assign tree_patch_in     = patch_a_q;
  assign tree_patch_two_en = en_b_q;
  assign tree_patch_two_in = patch_b_q;
  assign outstanding       = outstanding_q;
  assign err_orphan        = err_orphan_q;

  always_comb begin
    state_d    = state_q;
    node_cnt_d = node_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_load) begin
          state_d    = ST_LOAD;
          node_cnt_d = '0;
        end
      end
      ST_LOAD: begin
        if (node_wr_en) begin
          node_cnt_d = node_cnt_q + CNT_W'(1);
          if (node_cnt_q == CNT_W'(NUM_INTERNAL_NODES - 1)) state_d = ST_QUERY;
        end
      end
      ST_QUERY: begin
        // Reloading under in-flight queries would corrupt their lookups.
        if (start_load && (outstanding_q == '0)) begin
          state_d    = ST_LOAD;
          node_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    lane_ptr_d = lane_ptr_q;
    en_a_d     = 1'b0;
    en_b_d     = 1'b0;
    patch_a_d  = patch_a_q;
    patch_b_d  = patch_b_q;
    if (accept) begin
      lane_ptr_d = (lane_ptr_q == LANE_A) ? LANE_B : LANE_A;
      if (lane_ptr_q == LANE_A) begin
        en_a_d    = 1'b1;
        patch_a_d = q_patch;
      end else begin
        en_b_d    = 1'b1;
        patch_b_d = q_patch;
      end
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, deliver})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    err_orphan_d = err_orphan_q | (tree_leaf_en & tag_a_empty) |
                   (tree_leaf_two_en & tag_b_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      node_cnt_q    <= '0;
      lane_ptr_q    <= LANE_A;
      outstanding_q <= '0;
      err_orphan_q  <= 1'b0;
      en_a_q        <= 1'b0;
      en_b_q        <= 1'b0;
      patch_a_q     <= '0;
      patch_b_q     <= '0;
    end else begin
      state_q       <= state_d;
      node_cnt_q    <= node_cnt_d;
      lane_ptr_q    <= lane_ptr_d;
      outstanding_q <= outstanding_d;
      err_orphan_q  <= err_orphan_d;
      en_a_q        <= en_a_d;
      en_b_q        <= en_b_d;
      patch_a_q     <= patch_a_d;
      patch_b_q     <= patch_b_d;
    end
  end

  sched_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_INFLIGHT)) u_tag_a (
    .clk(clk), .rst(rst), .push(push_a), .din(q_tag), .pop(comp_a),
    .dout(tag_a_head), .full(tag_a_full), .empty(tag_a_empty)
  );

  sched_fifo #(.WIDTH(TAG_WIDTH), .DEPTH(MAX_INFLIGHT)) u_tag_b (
    .clk(clk), .rst(rst), .push(push_b), .din(q_tag), .pop(comp_b),
    .dout(tag_b_head), .full(tag_b_full), .empty(tag_b_empty)
  );

  sched_fifo #(.WIDTH(RES_W), .DEPTH(MAX_INFLIGHT)) u_res_a (
    .clk(clk), .rst(rst), .push(comp_a), .din({tag_a_head, tree_leaf_index}),
    .pop(deliver & ~head_is_b),
    .dout(res_a_head), .full(res_a_full), .empty(res_a_empty)
  );

  sched_fifo #(.WIDTH(RES_W), .DEPTH(MAX_INFLIGHT)) u_res_b (
    .clk(clk), .rst(rst), .push(comp_b), .din({tag_b_head, tree_leaf_index_two}),
    .pop(deliver & head_is_b),
    .dout(res_b_head), .full(res_b_full), .empty(res_b_empty)
  );

  sched_fifo #(.WIDTH(1), .DEPTH(MAX_INFLIGHT)) u_order (
    .clk(clk), .rst(rst), .push(accept), .din(lane_ptr_q), .pop(deliver),
    .dout(ord_head), .full(ord_full), .empty(ord_empty)
  );

endmodule

// File: tb/tb_tree_query_scheduler.sv
// Scoreboard bench for tree_query_scheduler with a two-lane delayed tree model.
module tb_tree_query_scheduler;

  logic        clk = 1'b0;
  logic        rst, start_load, node_wr_en;
  logic        tree_fsm_enable, load_done;
  logic        q_valid, q_ready;
  logic [54:0] q_patch;
  logic [7:0]  q_tag;
  logic        tree_patch_en, tree_patch_two_en;
  logic [54:0] tree_patch_in, tree_patch_two_in;
  logic        tree_leaf_en, tree_leaf_two_en;
  logic [7:0]  tree_leaf_index, tree_leaf_index_two;
  logic        r_valid, r_ready;
  logic [7:0]  r_tag, r_leaf;
  logic [3:0]  outstanding;
  logic        err_orphan;

  always #5 clk = ~clk;

  tree_query_scheduler dut (
    .clk(clk), .rst(rst), .start_load(start_load), .node_wr_en(node_wr_en),
    .tree_fsm_enable(tree_fsm_enable), .load_done(load_done),
    .q_valid(q_valid), .q_ready(q_ready), .q_patch(q_patch), .q_tag(q_tag),
    .tree_patch_en(tree_patch_en), .tree_patch_in(tree_patch_in),
    .tree_patch_two_en(tree_patch_two_en), .tree_patch_two_in(tree_patch_two_in),
    .tree_leaf_en(tree_leaf_en), .tree_leaf_index(tree_leaf_index),
    .tree_leaf_two_en(tree_leaf_two_en), .tree_leaf_index_two(tree_leaf_index_two),
    .r_valid(r_valid), .r_ready(r_ready), .r_tag(r_tag), .r_leaf(r_leaf),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [7:0] leaf;
    int         due;
  } tr_t;

  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;
  int         deliv_cyc[256];
  tr_t        qa[$], qb[$];
  tr_t        t_a, t_b;
  int         dly_a = 2, dly_b = 2;
  bit         inject_b = 1'b0;
  int         last_leaf_a_cyc = -1, last_leaf_b_cyc = -1;
  int         en_a_cyc = -1, en_b_cyc = -1, a_done_cnt = 0;
  bit         both_en = 1'b0;

  logic [54:0] P1, P2;

  function automatic logic [54:0] mk_patch(input int a, input int b, input int c,
                                           input int d, input int e);
    return {a[10:0], b[10:0], c[10:0], d[10:0], e[10:0]};
  endfunction

  // Lookup results the tree would produce for the directed patches.
  function automatic logic [7:0] leaf_of(input logic [54:0] p);
    if (p == mk_patch(251, -26, -1, -88, 79)) return 8'd59;
    if (p == mk_patch(279, -18, -55, -22, 18)) return 8'd60;
    return p[7:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fsm_en"}, tree_fsm_enable, 0);
    check({tag, "_load_done"}, load_done, 0);
    check({tag, "_q_ready"}, q_ready, 0);
    check({tag, "_patch_en"}, tree_patch_en, 0);
    check({tag, "_patch_two_en"}, tree_patch_two_en, 0);
    check({tag, "_patch_in"}, tree_patch_in, 0);
    check({tag, "_patch_two_in"}, tree_patch_two_in, 0);
    check({tag, "_r_valid"}, r_valid, 0);
    check({tag, "_r_tag"}, r_tag, 0);
    check({tag, "_r_leaf"}, r_leaf, 0);
    check({tag, "_outstanding"}, outstanding, 0);
    check({tag, "_err_orphan"}, err_orphan, 0);
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic offer(input logic [7:0] tag, input logic [54:0] patch,
                       input logic [7:0] leaf, input int max_cyc, output bit ok);
    ok = 1'b0;
    q_valid = 1'b1; q_tag = tag; q_patch = patch;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      #4;
      if (q_ready) begin
        ok = 1'b1;
        sb.push_back({tag, leaf});
      end
      @(negedge clk);
    end
    q_valid = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc && sb.size() != 0; i++) @(negedge clk);
    check({name, "_drain_left"}, sb.size(), 0);
  endtask

  task automatic do_load();
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
    for (int i = 0; i < 63; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      node_wr_en = 1'b1;
      #4;
      check("fsm_en_during_load", tree_fsm_enable, 1);
      check("load_done_during_load", load_done, 0);
      @(negedge clk);
      node_wr_en = 1'b0;
    end
    #4;
    check("fsm_en_after_load", tree_fsm_enable, 0);
    check("load_done_after_load", load_done, 1);
    @(negedge clk);
  endtask

  // Tree model: fixed per-lane latency, results in issue order per lane.
  initial begin
    tree_leaf_en = 1'b0; tree_leaf_index = '0;
    tree_leaf_two_en = 1'b0; tree_leaf_index_two = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      tree_leaf_en = 1'b0;
      tree_leaf_two_en = 1'b0;
      if (rst) begin
        qa.delete();
        qb.delete();
      end else begin
        if (tree_patch_en && tree_patch_two_en) both_en = 1'b1;
        if (tree_patch_en) begin
          qa.push_back('{leaf_of(tree_patch_in), cyc + dly_a});
          en_a_cyc = cyc;
        end
        if (tree_patch_two_en) begin
          qb.push_back('{leaf_of(tree_patch_two_in), cyc + dly_b});
          en_b_cyc = cyc;
        end
        if (qa.size() > 0 && qa[0].due <= cyc) begin
          t_a = qa.pop_front();
          tree_leaf_en = 1'b1;
          tree_leaf_index = t_a.leaf;
          last_leaf_a_cyc = cyc;
          a_done_cnt++;
        end
        if (inject_b) begin
          tree_leaf_two_en = 1'b1;
          tree_leaf_index_two = 8'hEE;
        end else if (qb.size() > 0 && qb[0].due <= cyc) begin
          t_b = qb.pop_front();
          tree_leaf_two_en = 1'b1;
          tree_leaf_index_two = t_b.leaf;
          last_leaf_b_cyc = cyc;
        end
      end
    end
  end

  // Monitor: every delivered result is compared with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (r_valid && r_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_result: got tag %0d leaf %0d, expected none", r_tag, r_leaf);
        end else begin
          mon_exp = sb.pop_front();
          check("result_tag_leaf", {r_tag, r_leaf}, mon_exp);
          deliv_cyc[r_tag] = cyc;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc, early, a_before;
    P1 = mk_patch(251, -26, -1, -88, 79);
    P2 = mk_patch(279, -18, -55, -22, 18);
    rst = 1'b1; start_load = 1'b0; node_wr_en = 1'b0;
    q_valid = 1'b0; q_patch = '0; q_tag = '0; r_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check_all_zero("reset");
    @(negedge clk);

    // 1: load phase; writes outside LOAD are ignored
    node_wr_en = 1'b1;
    @(negedge clk);
    node_wr_en = 1'b0;
    #4;
    check("idle_write_fsm_en", tree_fsm_enable, 0);
    check("idle_write_load_done", load_done, 0);
    @(negedge clk);
    do_load();
    node_wr_en = 1'b1;
    @(negedge clk);
    node_wr_en = 1'b0;
    #4;
    check("write64_load_done", load_done, 1);
    check("write64_fsm_en", tree_fsm_enable, 0);
    check("query_q_ready", q_ready, 1);
    @(negedge clk);

    // 2: back-to-back queries alternate lanes, in-order results
    dly_a = 3; dly_b = 3;
    offer(8'd1, P1, 8'd59, 5, ok);
    offer(8'd2, P2, 8'd60, 5, ok);
    drain("t2", 40);
    check("t2_lane_b_follows_a", en_b_cyc - en_a_cyc, 1);
    check("t2_min_latency", deliv_cyc[1] - last_leaf_a_cyc, 1);

    // 3: lane B finishes first; delivery must wait for lane A
    dly_a = 6; dly_b = 2;
    a_before = a_done_cnt;
    early = 0;
    offer(8'd3, mk_patch(3, -3, 5, 0, 103), 8'd103, 5, ok);
    offer(8'd4, mk_patch(4, -4, 5, 0, 104), 8'd104, 5, ok);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      #4;
      if (a_done_cnt == a_before && r_valid) early++;
      @(negedge clk);
    end
    check("t3_r_valid_before_lane_a", early, 0);
    check("t3_b_before_a", (last_leaf_b_cyc < last_leaf_a_cyc), 1);
    drain("t3", 10);

    // 4: credit limit with r_ready low
    dly_a = 2; dly_b = 2;
    r_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      offer(8'(10 + i), mk_patch(i, 1, 2, 3, 110 + i), 8'(110 + i), 3, ok);
      if (ok) acc++;
    end
    check("t4_accepted", acc, 8);
    repeat (6) @(negedge clk);
    #4;
    check("t4_outstanding_full", outstanding, 8);
    check("t4_q_ready_low", q_ready, 0);
    check("t4_r_valid_held", r_valid, 1);
    @(negedge clk);
    r_ready = 1'b1;
    offer(8'd18, mk_patch(8, 1, 2, 3, 118), 8'd118, 40, ok);
    check("t4_late_accept_18", ok, 1);
    offer(8'd19, mk_patch(9, 1, 2, 3, 119), 8'd119, 40, ok);
    check("t4_late_accept_19", ok, 1);
    drain("t4", 80);
    #4;
    check("t4_outstanding_empty", outstanding, 0);
    @(negedge clk);

    // 5: orphan completion on lane B
    inject_b = 1'b1;
    @(negedge clk);
    inject_b = 1'b0;
    @(negedge clk);
    #4;
    check("t5_err_orphan_set", err_orphan, 1);
    check("t5_no_r_valid", r_valid, 0);
    repeat (5) @(negedge clk);
    #4;
    check("t5_err_orphan_sticky", err_orphan, 1);
    check("t5_no_r_valid_later", r_valid, 0);
    @(negedge clk);

    // 6: reset with queries in flight
    dly_a = 30; dly_b = 30;
    for (int i = 0; i < 4; i++) offer(8'(40 + i), mk_patch(i, 0, 0, 0, 140 + i), 8'(140 + i), 5, ok);
    #4;
    check("t6_outstanding_before_rst", outstanding, 4);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #4;
    check_all_zero("midrst");
    @(negedge clk);
    offer(8'd49, mk_patch(0, 0, 0, 0, 149), 8'd149, 3, ok);
    check("t6_no_accept_in_idle", ok, 0);
    sb.delete();
    dly_a = 2; dly_b = 2;
    do_load();
    #4;
    check("t6_q_ready_after_load", q_ready, 1);
    @(negedge clk);
    repeat (40) @(negedge clk);
    #4;
    check("t6_no_late_orphan", err_orphan, 0);
    @(negedge clk);
    offer(8'd50, mk_patch(5, 5, 5, 5, 150), 8'd150, 5, ok);
    drain("t6", 40);

    check("never_both_lanes", both_en, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
